// File: rtl/cpu_bus_if_pkg.sv
// Shared types and constants for the CPU memory-bus front end and the control FSM.
package cpu_bus_if_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      WAIT = 2'd2,
      CAPT = 2'd3
   } bus_state_t;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int WCNT_W     = 4;

   // Opcode the controller treats as "do nothing"; the IR comes out of reset holding it.
   localparam logic [DATA_W_DEF-1:0] NOP_OPCODE = 8'h00;

endpackage

// File: rtl/cpu_bus_if_if.sv
// Request/response and RAM-side signals of the bus front end, bundled with master/slave views.
interface cpu_bus_if_if
   import cpu_bus_if_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic              rd_req;
   logic              wr_req;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              ir_load;
   logic              bus_ready;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] instruction;
   logic              bus_err;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_oe;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Master: the controller plus the RAM that sits behind the front end.
   modport master (
      output rd_req, wr_req, req_addr, req_wdata, ir_load, mem_rdata,
      input  bus_ready, rd_data, instruction, bus_err,
      input  mem_addr, mem_oe, mem_we, mem_wdata
   );

   modport slave (
      input  rd_req, wr_req, req_addr, req_wdata, ir_load, mem_rdata,
      output bus_ready, rd_data, instruction, bus_err,
      output mem_addr, mem_oe, mem_we, mem_wdata
   );

endinterface

// File: rtl/cpu_bus_if_wait_ctr.sv
// Loadable down-counter with zero flag; stops at zero instead of wrapping.
module bus_wait_ctr
   import cpu_bus_if_pkg::*;
#(
   parameter int W = WCNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         dec_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cpu_bus_if.sv
// Memory-bus front end: runs one RAM read/write at a time with programmable wait states
// and holds the fetched opcode in the instruction register for the control FSM.
module cpu_bus_if
   import cpu_bus_if_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WAIT_STATES = 2
) (
   input logic         clk,
   input logic         reset_cycle,
   cpu_bus_if_if.slave bus
);

   localparam logic [WCNT_W-1:0] WAIT_LOAD =
      (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;

   bus_state_t        state_q, state_d;
   logic              is_wr_q, is_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic              err_q, err_d;
   logic              req;
   logic              wc_zero;

   assign req = bus.rd_req | bus.wr_req;

   bus_wait_ctr #(.W(WCNT_W)) u_wait_ctr (
      .clk        (clk),
      .rst        (reset_cycle),
      .load_i     (state_q == ADDR),
      .dec_i      (state_q == WAIT),
      .load_val_i (WAIT_LOAD),
      .zero_o     (wc_zero)
   );

   always_ff @(posedge clk or posedge reset_cycle) begin
      if (reset_cycle) state_q <= IDLE;
      else             state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req) state_d = ADDR;
         ADDR:    state_d = (WAIT_STATES == 0) ? CAPT : WAIT;
         WAIT:    if (wc_zero) state_d = CAPT;
         CAPT:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Write wins a simultaneous request; ir_load only counts when bus_ready would be high.
   always_comb begin
      is_wr_d   = is_wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rd_data_d = rd_data_q;
      ir_d      = ir_q;
      err_d     = err_q;
      if (state_q == IDLE) begin
         if (req) begin
            is_wr_d = bus.wr_req;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
         end else if (bus.ir_load) begin
            ir_d = rd_data_q;
         end
      end else if (req) begin
         err_d = 1'b1;
      end
      if ((state_d == CAPT) && !is_wr_q) rd_data_d = bus.mem_rdata;
   end

   always_ff @(posedge clk or posedge reset_cycle) begin
      if (reset_cycle) begin
         is_wr_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_data_q <= '0;
         ir_q      <= DATA_W'(NOP_OPCODE);
         err_q     <= 1'b0;
      end else begin
         is_wr_q   <= is_wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rd_data_q <= rd_data_d;
         ir_q      <= ir_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      bus.bus_ready = (state_q == IDLE) && !req;
      bus.mem_oe    = 1'b0;
      bus.mem_we    = 1'b0;
      if ((state_q == ADDR) || (state_q == WAIT)) begin
         bus.mem_oe = !is_wr_q;
         bus.mem_we = is_wr_q;
      end
   end

   assign bus.mem_addr    = addr_q;
   assign bus.mem_wdata   = wdata_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.instruction = ir_q;
   assign bus.bus_err     = err_q;

endmodule

// File: tb/tb_cpu_bus_if.sv
// Drives three builds (WAIT_STATES = 2, 0, 15) in lockstep and checks each against a
// transaction-level model of the bus front end.
module tb_cpu_bus_if;
   import cpu_bus_if_pkg::*;

   localparam int N = 3;

   function automatic int ws_of(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 0 : 15);
   endfunction

   function automatic int lat_of(input int i);
      return (i == 0) ? 5 : ((i == 1) ? 3 : 18);
   endfunction

   logic       clk = 1'b0;
   logic       reset_cycle, rd_req, wr_req, ir_load;
   logic [7:0] req_addr, req_wdata;

   logic [N-1:0] ready_a, oe_a, we_a, err_a;
   logic [7:0]   rdd_a [N];
   logic [7:0]   ins_a [N];
   logic [7:0]   ma_a  [N];
   logic [7:0]   mwd_a [N];
   logic [7:0]   ram   [N][256];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int WS = (g == 0) ? 2 : ((g == 1) ? 0 : 15);
      cpu_bus_if_if #(.ADDR_W(8), .DATA_W(8)) bus ();
      cpu_bus_if #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(WS)) dut (
         .clk         (clk),
         .reset_cycle (reset_cycle),
         .bus         (bus)
      );
      assign bus.rd_req    = rd_req;
      assign bus.wr_req    = wr_req;
      assign bus.req_addr  = req_addr;
      assign bus.req_wdata = req_wdata;
      assign bus.ir_load   = ir_load;
      assign bus.mem_rdata = ram[g][bus.mem_addr];
      assign ready_a[g]    = bus.bus_ready;
      assign oe_a[g]       = bus.mem_oe;
      assign we_a[g]       = bus.mem_we;
      assign err_a[g]      = bus.bus_err;
      assign rdd_a[g]      = bus.rd_data;
      assign ins_a[g]      = bus.instruction;
      assign ma_a[g]       = bus.mem_addr;
      assign mwd_a[g]      = bus.mem_wdata;
   end

   // Transaction model: m_k counts cycles since acceptance (1..1+WS strobes, 2+WS capture).
   bit         m_busy [N];
   int         m_k    [N];
   bit         m_wr   [N];
   logic [7:0] m_addr [N];
   logic [7:0] m_wdata[N];
   logic [7:0] m_rdd  [N];
   logic [7:0] m_ir   [N];
   bit         m_err  [N];
   logic [7:0] m_mem  [N][256];

   logic [N-1:0] s_ready, s_we;
   logic [7:0]   s_wa [N];
   logic [7:0]   s_wd [N];
   int           lat  [N];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s ws=%0d t=%0t got=%0h want=%0h", nm, ws_of(i), $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_busy[i] = 1'b0; m_k[i] = 0; m_wr[i] = 1'b0;
         m_addr[i] = 8'h00; m_wdata[i] = 8'h00;
         m_rdd[i] = 8'h00; m_ir[i] = 8'h00; m_err[i] = 1'b0;
      end
   endtask

   task automatic model_step(input int i, input bit rd, input bit wr,
                             input logic [7:0] a, input logic [7:0] d, input bit ir);
      int ws;
      ws = ws_of(i);
      if (m_busy[i]) begin
         if (rd || wr) m_err[i] = 1'b1;
         if (m_wr[i] && (m_k[i] <= 1 + ws)) m_mem[i][m_addr[i]] = m_wdata[i];
         if (!m_wr[i] && (m_k[i] == 1 + ws)) m_rdd[i] = m_mem[i][m_addr[i]];
         if (m_k[i] == 2 + ws) m_busy[i] = 1'b0;
         else                  m_k[i]++;
      end else begin
         if (ir && !rd && !wr) m_ir[i] = m_rdd[i];
         if (rd || wr) begin
            m_busy[i] = 1'b1; m_k[i] = 1; m_wr[i] = wr;
            m_addr[i] = a; m_wdata[i] = d;
         end
      end
   endtask

   // One clock: drive at negedge, compare against the model, then advance DUTs, RAMs and model.
   task automatic cycle(input bit rd, input bit wr, input logic [7:0] a,
                        input logic [7:0] d, input bit ir);
      bit strobe;
      @(negedge clk);
      rd_req = rd; wr_req = wr; req_addr = a; req_wdata = d; ir_load = ir;
      #1;
      for (int i = 0; i < N; i++) begin
         strobe = m_busy[i] && (m_k[i] <= 1 + ws_of(i));
         chk("bus_ready",   i, 8'(ready_a[i]), 8'(!m_busy[i] && !rd && !wr));
         chk("mem_oe",      i, 8'(oe_a[i]),    8'(strobe && !m_wr[i]));
         chk("mem_we",      i, 8'(we_a[i]),    8'(strobe && m_wr[i]));
         if (strobe)            chk("mem_addr",  i, ma_a[i],  m_addr[i]);
         if (strobe && m_wr[i]) chk("mem_wdata", i, mwd_a[i], m_wdata[i]);
         chk("rd_data",     i, rdd_a[i],       m_rdd[i]);
         chk("instruction", i, ins_a[i],       m_ir[i]);
         chk("bus_err",     i, 8'(err_a[i]),   8'(m_err[i]));
         s_ready[i] = ready_a[i];
         s_we[i]    = we_a[i];
         s_wa[i]    = ma_a[i];
         s_wd[i]    = mwd_a[i];
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (s_we[i]) ram[i][s_wa[i]] = s_wd[i];
         model_step(i, rd, wr, a, d, ir);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      for (int i = 0; i < N; i++) lat[i] = 0;
      do begin
         cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
         n++;
         for (int i = 0; i < N; i++) if (s_ready[i] && (lat[i] == 0)) lat[i] = n;
      end while ((s_ready != '1) && (n < 40));
   endtask

   // Async reset pulsed between clock edges; outputs must change without waiting for a clock.
   task automatic pulse_reset();
      #1;
      rd_req = 1'b0; wr_req = 1'b0; ir_load = 1'b0;
      reset_cycle = 1'b1;
      #1;
      for (int i = 0; i < N; i++) begin
         chk("rst_mem_oe",      i, 8'(oe_a[i]),    8'h00);
         chk("rst_mem_we",      i, 8'(we_a[i]),    8'h00);
         chk("rst_bus_ready",   i, 8'(ready_a[i]), 8'h01);
         chk("rst_rd_data",     i, rdd_a[i],       8'h00);
         chk("rst_instruction", i, ins_a[i],       8'h00);
         chk("rst_bus_err",     i, 8'(err_a[i]),   8'h00);
         chk("rst_mem_addr",    i, ma_a[i],        8'h00);
      end
      #1;
      reset_cycle = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [7:0] v;
      reset_cycle = 1'b0; rd_req = 1'b0; wr_req = 1'b0; ir_load = 1'b0;
      req_addr = 8'h00; req_wdata = 8'h00;
      for (int i = 0; i < N; i++) begin
         for (int a = 0; a < 256; a++) begin
            v = 8'($urandom);
            ram[i][a] = v;
            m_mem[i][a] = v;
         end
         ram[i][8'h10] = 8'h18; m_mem[i][8'h10] = 8'h18;
         ram[i][8'h20] = 8'h00; m_mem[i][8'h20] = 8'h00;
      end
      @(posedge clk);
      pulse_reset();

      // Read 0x10 -> 0x18, latency 3+WAIT_STATES
      cycle(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
      wait_idle();
      for (int i = 0; i < N; i++) begin
         chk("read_latency", i, 8'(lat[i]), 8'(lat_of(i)));
         chk("read_0x10",    i, rdd_a[i],   8'h18);
      end

      cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      for (int i = 0; i < N; i++) chk("ir_load", i, ins_a[i], 8'h18);

      // Write 0xA5 to 0x20; rd_data untouched, then read it back
      cycle(1'b0, 1'b1, 8'h20, 8'hA5, 1'b0);
      wait_idle();
      for (int i = 0; i < N; i++) begin
         chk("write_latency", i, 8'(lat[i]),     8'(lat_of(i)));
         chk("wr_keeps_rd",   i, rdd_a[i],       8'h18);
         chk("ram_0x20",      i, ram[i][8'h20],  8'hA5);
      end
      cycle(1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
      wait_idle();
      for (int i = 0; i < N; i++) chk("readback_0x20", i, rdd_a[i], 8'hA5);

      // ir_load alongside a request must not load the IR
      cycle(1'b1, 1'b0, 8'h10, 8'h00, 1'b1);
      for (int i = 0; i < N; i++) chk("ir_blocked", i, ins_a[i], 8'h18);
      wait_idle();

      // Simultaneous rd+wr is a write with no error; request while busy sets the sticky error
      cycle(1'b1, 1'b1, 8'h40, 8'h5A, 1'b0);
      wait_idle();
      for (int i = 0; i < N; i++) begin
         chk("both_req_err", i, 8'(err_a[i]),   8'h00);
         chk("ram_0x40",     i, ram[i][8'h40],  8'h5A);
      end
      cycle(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 8'h11, 8'h00, 1'b0);
      wait_idle();
      cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < N; i++) chk("busy_req_err", i, 8'(err_a[i]), 8'h01);

      // Reset in the middle of a read
      cycle(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      pulse_reset();

      for (int n = 0; n < 800; n++) begin
         cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
               8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 99) < 30);
         if ($urandom_range(0, 99) == 0) pulse_reset();
      end
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
